// File: rtl/flexcim_feeder.sv
// rtl/flexcim_feeder.sv - command sequencer and beat FIFO driving the flexcim input side
module flexcim_feeder #(
  parameter int NUM_INPUT_DATA = 4,
  parameter int NUM_SUB_MACROS = 4,
  parameter int DATA_WIDTH     = 9,
  parameter int NUM_ROWS       = 32,
  parameter int NUM_COLS       = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int DRAIN_CYCLES   = 2,
  localparam int DW = NUM_ROWS*NUM_SUB_MACROS*NUM_INPUT_DATA*2*DATA_WIDTH,
  localparam int SW = NUM_ROWS*2*NUM_SUB_MACROS*2,
  localparam int CW = NUM_SUB_MACROS*NUM_COLS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic                      cfg_op,
  input  logic [NUM_SUB_MACROS-1:0] cfg_en,
  input  logic [CW-1:0]             cfg_col_mask,
  input  logic [15:0]               cfg_count,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DW-1:0]             s_data,
  input  logic [SW-1:0]             s_sparse,
  output logic [NUM_SUB_MACROS-1:0] en,
  output logic [NUM_ROWS-1:0]       i_valid,
  output logic [DW-1:0]             i_data_bus,
  output logic [SW-1:0]             i_sparse_select,
  output logic [CW-1:0]             sel_cols,
  output logic [CW-1:0]             write_en,
  output logic                      busy,
  output logic                      done
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BW  = DW + SW;
  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [BW-1:0]             r_mem [FIFO_DEPTH];
  logic [AW:0]               r_wr_ptr;
  logic [AW:0]               r_rd_ptr;
  logic                      r_op;
  logic [NUM_SUB_MACROS-1:0] r_cfg_en;
  logic [CW-1:0]             r_mask;
  logic [15:0]               r_remaining;
  logic [DCW-1:0]            r_drain_cnt;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_accept;
  logic [BW-1:0] w_head;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign s_ready  = ~w_full;
  assign w_push   = s_valid & ~w_full;
  assign w_pop    = (r_state == S_RUN) & ~w_empty;
  assign w_accept = (r_state == S_IDLE) & cfg_valid;
  assign w_head   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {s_data, s_sparse};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = (cfg_count == 16'd0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (w_pop && r_remaining == 16'd1) w_state_nxt = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (r_drain_cnt == DCW'(DRAIN_CYCLES - 1)) w_state_nxt = S_DONE;
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= 1'b0;
      r_cfg_en    <= '0;
      r_mask      <= '0;
      r_remaining <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op        <= cfg_op;
        r_cfg_en    <= cfg_en;
        r_mask      <= cfg_col_mask;
        r_remaining <= cfg_count;
      end else if (w_pop) begin
        r_remaining <= r_remaining - 16'd1;
      end
      r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + DCW'(1) : '0;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ready       <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      en              <= '0;
      i_valid         <= '0;
      i_data_bus      <= '0;
      i_sparse_select <= '0;
      sel_cols        <= '0;
      write_en        <= '0;
    end else begin
      cfg_ready       <= (w_state_nxt == S_IDLE);
      busy            <= (w_state_nxt != S_IDLE);
      done            <= (w_state_nxt == S_DONE);
      en              <= (w_state_nxt == S_RUN || w_state_nxt == S_DRAIN)
                         ? (w_accept ? cfg_en : r_cfg_en) : '0;
      i_valid         <= w_pop ? '1 : '0;
      i_data_bus      <= w_pop ? w_head[BW-1:SW] : '0;
      i_sparse_select <= w_pop ? w_head[SW-1:0] : '0;
      sel_cols        <= w_pop ? r_mask : '0;
      write_en        <= (w_pop && r_op) ? r_mask : '0;
    end
  end

endmodule

// File: tb/tb_flexcim_feeder.sv
// tb/tb_flexcim_feeder.sv - directed bench for flexcim_feeder with a beat scoreboard
module tb_flexcim_feeder;

  localparam int NSM = 4;
  localparam int NR  = 32;
  localparam int NC  = 32;
  localparam int DW  = NR*NSM*4*2*9;
  localparam int SW  = NR*2*NSM*2;
  localparam int CW  = NSM*NC;
  localparam int BW  = DW + SW;

  typedef logic [BW-1:0] beat_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_valid;
  logic           cfg_ready;
  logic           cfg_op;
  logic [NSM-1:0] cfg_en;
  logic [CW-1:0]  cfg_col_mask;
  logic [15:0]    cfg_count;
  logic           s_valid;
  logic           s_ready;
  logic [DW-1:0]  s_data;
  logic [SW-1:0]  s_sparse;
  logic [NSM-1:0] en;
  logic [NR-1:0]  i_valid;
  logic [DW-1:0]  i_data_bus;
  logic [SW-1:0]  i_sparse_select;
  logic [CW-1:0]  sel_cols;
  logic [CW-1:0]  write_en;
  logic           busy;
  logic           done;

  int            total = 0;
  int            bad = 0;
  beat_t         beat_q[$];
  beat_t         mon_b;
  logic          exp_op = 1'b0;
  logic [CW-1:0] exp_mask = '0;
  bit            mon_on = 1'b0;

  always #5 clk = ~clk;

  flexcim_feeder dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_op(cfg_op), .cfg_en(cfg_en),
    .cfg_col_mask(cfg_col_mask), .cfg_count(cfg_count),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sparse(s_sparse),
    .en(en), .i_valid(i_valid), .i_data_bus(i_data_bus), .i_sparse_select(i_sparse_select),
    .sel_cols(sel_cols), .write_en(write_en), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    for (int k = 0; k < BW/32; k++) b[k*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [CW-1:0] rand_mask();
    logic [CW-1:0] m;
    for (int k = 0; k < CW/32; k++) m[k*32 +: 32] = $urandom;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input bit expect_ready);
    beat_t b;
    b = rand_beat();
    s_valid = 1'b1;
    {s_data, s_sparse} = b;
    check("s_ready_at_push", 128'(s_ready), 128'(expect_ready));
    if (s_ready) beat_q.push_back(b);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic chk_cyc(input string tn, input bit ev, input logic [NSM-1:0] een,
                         input bit ed, input bit eb);
    check({tn, "_ivalid"}, 128'(i_valid), ev ? 128'({NR{1'b1}}) : 128'(0));
    check({tn, "_en"}, 128'(en), 128'(een));
    check({tn, "_done"}, 128'(done), 128'(ed));
    check({tn, "_busy"}, 128'(busy), 128'(eb));
    check({tn, "_cfg_ready"}, 128'(cfg_ready), 128'(!eb));
  endtask

  task automatic send_cfg(input logic op, input logic [NSM-1:0] e, input logic [15:0] cnt);
    cfg_valid = 1'b1;
    cfg_op = op;
    cfg_en = e;
    cfg_col_mask = exp_mask;
    cfg_count = cnt;
    check("cfg_ready_at_issue", 128'(cfg_ready), 128'(1));
  endtask

  // Scoreboard: every driven output beat must match the oldest accepted push.
  always @(negedge clk) begin
    if (mon_on) begin
      if (i_valid !== '0) begin
        if (beat_q.size() == 0) begin
          check("unexpected_beat", 128'(i_valid), 128'(0));
        end else begin
          mon_b = beat_q.pop_front();
          check("beat_ivalid", 128'(i_valid), 128'({NR{1'b1}}));
          check("beat_sel_cols", 128'(sel_cols), 128'(exp_mask));
          check("beat_write_en", 128'(write_en), exp_op ? 128'(exp_mask) : 128'(0));
          total++;
          assert (i_data_bus === mon_b[BW-1:SW]) else begin
            bad++;
            $error("FAIL beat_data observed=%h expected=%h", i_data_bus[63:0], mon_b[SW+63:SW]);
          end
          total++;
          assert (i_sparse_select === mon_b[SW-1:0]) else begin
            bad++;
            $error("FAIL beat_sparse observed=%h expected=%h", i_sparse_select[63:0], mon_b[63:0]);
          end
        end
      end else begin
        check("idle_zero", 128'((i_data_bus === '0) && (i_sparse_select === '0) &&
                                (sel_cols === '0) && (write_en === '0)), 128'(1));
      end
    end
  end

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_op = 1'b0;
    cfg_en = '0;
    cfg_col_mask = '0;
    cfg_count = '0;
    s_valid = 1'b0;
    s_data = '0;
    s_sparse = '0;
    tick();
    tick();
    check("rst_cfg_ready", 128'(cfg_ready), 128'(1));
    check("rst_s_ready", 128'(s_ready), 128'(1));
    check("rst_en", 128'(en), 128'(0));
    check("rst_ivalid", 128'(i_valid), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    rst = 1'b0;
    mon_on = 1'b1;
    tick();

    // Compute, three pre-pushed beats, bit 0 of each sub-macro selected.
    repeat (3) push_beat(1'b1);
    exp_op = 1'b0;
    exp_mask = '0;
    for (int m = 0; m < NSM; m++) exp_mask[m*NC] = 1'b1;
    send_cfg(1'b0, 4'hF, 16'd3);
    tick();
    cfg_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      chk_cyc("cmp3", (c >= 2 && c <= 4), (c <= 5) ? 4'hF : 4'h0, c == 6, c <= 6);
      tick();
    end

    // Weight write with beats arriving at T+5 and T+9.
    exp_op = 1'b1;
    exp_mask = rand_mask();
    send_cfg(1'b1, 4'b0101, 16'd2);
    tick();
    cfg_valid = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      chk_cyc("ww", (c == 7 || c == 11), (c <= 12) ? 4'b0101 : 4'b0000, c == 13, c <= 13);
      if (c == 5 || c == 9) push_beat(1'b1);
      else tick();
    end

    // FIFO full: fifth beat refused at T and at T+1 (pop in the same cycle).
    repeat (4) push_beat(1'b1);
    check("full_s_ready", 128'(s_ready), 128'(0));
    exp_op = 1'b0;
    exp_mask = rand_mask();
    s_valid = 1'b1;
    {s_data, s_sparse} = rand_beat();
    send_cfg(1'b0, 4'hF, 16'd4);
    tick();
    cfg_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 1) check("full_refuse_with_pop", 128'(s_ready), 128'(0));
      if (c == 2) begin
        s_valid = 1'b0;
        check("s_ready_after_pop", 128'(s_ready), 128'(1));
      end
      chk_cyc("full4", (c >= 2 && c <= 5), (c <= 6) ? 4'hF : 4'h0, c == 7, c <= 7);
      tick();
    end

    // Zero-length command.
    send_cfg(1'b1, 4'hF, 16'd0);
    tick();
    cfg_valid = 1'b0;
    chk_cyc("cnt0_t1", 1'b0, 4'h0, 1'b1, 1'b1);
    tick();
    chk_cyc("cnt0_t2", 1'b0, 4'h0, 1'b0, 1'b0);

    // Reset after the first of three beats has been popped.
    exp_op = 1'b0;
    exp_mask = rand_mask();
    repeat (3) push_beat(1'b1);
    send_cfg(1'b0, 4'hF, 16'd3);
    tick();
    cfg_valid = 1'b0;
    chk_cyc("mid_t1", 1'b0, 4'hF, 1'b0, 1'b1);
    tick();
    chk_cyc("mid_t2", 1'b1, 4'hF, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    beat_q.delete();
    chk_cyc("mid_rst", 1'b0, 4'h0, 1'b0, 1'b0);
    check("mid_rst_s_ready", 128'(s_ready), 128'(1));
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_cyc("post_rst", 1'b0, 4'h0, 1'b0, 1'b0);
    end

    exp_op = 1'b1;
    exp_mask = rand_mask();
    repeat (2) push_beat(1'b1);
    send_cfg(1'b1, 4'b0011, 16'd2);
    tick();
    cfg_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk_cyc("rerun", (c == 2 || c == 3), (c <= 4) ? 4'b0011 : 4'b0000, c == 5, c <= 5);
      tick();
    end

    tick();
    check("queue_empty", 128'(beat_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
